alarm_annunciator: RTL and testbench
====================================

Name: alarm_annunciator

Overview:
- Parametrised N-channel successor to the 3-input H/DC/C alarm FSM, feeding the same AA* indicator outputs.
- Each channel gets optional input synchronisation, a persistence filter, acknowledge handling and optional latching of unacknowledged alarms.
- Aggregate outputs (horn, active count, first-out index) go to the panel/indicator logic.
- All outputs are Moore: decoded only from registered state.

Parameters:
- N_CH, 3, number of alarm channels (>=1).
- PERSIST, 4, consecutive synchronised-high samples needed to raise an alarm (>=1).
- SYNC_STAGES, 2, synchroniser flops on alm_in (0 = bypass).
- LATCH, 1, 1 = an unacknowledged alarm that clears holds in RTN until acked; 0 = returns directly to IDLE.
- CW, $clog2(N_CH+1), width of active_cnt.
- IW, max(1,$clog2(N_CH)), width of first_idx.

Ports:
- CLK  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- alm_in  in  N_CH  raw alarm conditions; may be asynchronous.
- mask  in  N_CH  synchronous per-channel inhibit.
- ack  in  1  synchronous global acknowledge; level-sensitive, sampled every edge.
- alarm_o  out  N_CH  channel in ACTIVE or ACKED.
- unack_o  out  N_CH  channel in ACTIVE or RTN.
- horn  out  1  OR of unack_o.
- active_cnt  out  CW  popcount of alarm_o.
- first_vld  out  1  any unack_o set.
- first_idx  out  IW  lowest index with unack_o=1; 0 when first_vld=0.

Behaviour:
- Reset (reset_n=0, asynchronous): all channels IDLE, persistence counters 0, synchroniser flops 0. Every output is 0 immediately.
- Effective input: e[i] = sync(alm_in[i]) & ~mask[i]. Mask and ack are not synchronised.
- Per-channel states and encoded outputs (alarm,unack):
  - IDLE 00
  - PEND 00
  - ACTIVE 11
  - ACKED 10
  - RTN 01
- IDLE: e=1 -> PEND with cnt=1, or directly to ACTIVE if PERSIST=1. Otherwise stay.
- PEND: e=0 -> IDLE with cnt=0. e=1 and cnt==PERSIST-1 -> ACTIVE. Else cnt+1. ack is ignored.
- ACTIVE:
  - e=1 & ack -> ACKED.
  - e=0 -> RTN if LATCH=1 and ack=0; otherwise IDLE (covers ack=1, and LATCH=0 regardless of ack).
  - e=1 & ~ack -> stay.
- ACKED: e=0 -> IDLE. Otherwise stay; ack has no effect.
- RTN:
  - e=1 & ack -> ACKED.
  - e=1 & ~ack -> ACTIVE (no persistence on re-assertion).
  - e=0 & ack -> IDLE.
  - else stay.
- Release is immediate: no persistence filter on falling inputs.
- Mask: mask[i]=1 forces e=0, so a masked channel exits toward IDLE per the rules above. A latched ACTIVE passes through RTN and needs ack. Masking never creates an alarm.
- Latency: counting the first edge that samples alm_in high as edge 1, alarm_o/unack_o rise after edge SYNC_STAGES+PERSIST (defaults: edge 6). The input must stay high throughout, or PEND restarts.
- Release latency: alm_in falling -> state change after edge SYNC_STAGES+1.
- Ack latency: ack high at edge k -> unack_o clears after edge k.
- Aggregates:
  - Decoded combinationally from state registers only, with no combinational path from any input.
  - active_cnt ranges 0..N_CH and never wraps.
  - first_idx uses fixed lowest-index priority.
- Reset mid-operation: all state is lost. An input still high after reset_n deasserts needs the full latency again.
- Counter width is $clog2(PERSIST+1). The counter saturates conceptually; it never exceeds PERSIST-1.

Test Plan:
- Defaults: alm_in=3'b001 held high from edge 1 -> alarm_o=001, unack_o=001, horn=1, active_cnt=1, first_idx=0 after edge 6. Outputs stay 0 through edge 5.
- Glitch: alm_in[1] high for 3 edges then low (PERSIST=4) -> no output change at any edge; channel returns to IDLE.
- Latch: ch2 ACTIVE, alm_in[2] drops, no ack -> alarm_o=000, unack_o=100 (RTN). One-cycle ack -> all 0. Repeat with LATCH=0 -> straight to 000/000.
- Ack then clear: ch0 and ch1 ACTIVE; ack one cycle -> unack_o=000, alarm_o=011, horn=0. Drop alm_in[0] -> alarm_o=010, active_cnt=1.
- Simultaneous: all three ACTIVE; ack pulse and alm_in[1] falling reach the FSM on the same edge -> ch1 IDLE, ch0/ch2 ACKED, alarm_o=101, horn=0. Re-raise ch1 -> first_idx=1, horn=1 after full latency.
- Reset/mask: reset_n low mid-PEND and while ACTIVE -> outputs 0 asynchronously; full latency needed after release. mask[0]=1 during persistence -> no alarm raised. N_CH=8 sweep -> active_cnt reaches 8 and first_idx stays correct.

Source files
------------

// File: rtl/alarm_annunciator.sv
// N-channel alarm annunciator: per-channel sync, persistence filter, ack and
// optional latching of unacknowledged returns, with horn/count/first-out aggregates.
module alarm_ch #(
    parameter int PERSIST = 4,
    parameter int LATCH   = 1
) (
    input  logic CLK,
    input  logic reset_n,
    input  logic e,
    input  logic ack,
    output logic alarm,
    output logic unack
);
    localparam int PW = $clog2(PERSIST + 1);
    localparam logic [PW-1:0] CNT_LAST = PW'(PERSIST - 1);

    // Encoding puts alarm/unack directly in state bits [1:0], so outputs are pure flops.
    typedef enum logic [2:0] {
        IDLE   = 3'b000,
        PEND   = 3'b100,
        ACTIVE = 3'b011,
        ACKED  = 3'b010,
        RTN    = 3'b001
    } state_t;

    state_t        state;
    logic [PW-1:0] cnt;

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: if (e) begin
                    if (PERSIST == 1) state <= ACTIVE;
                    else begin
                        state <= PEND;
                        cnt   <= PW'(1);
                    end
                end
                PEND: begin
                    if (!e) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= ACTIVE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + PW'(1);
                    end
                end
                ACTIVE: begin
                    if (!e)       state <= (LATCH != 0 && !ack) ? RTN : IDLE;
                    else if (ack) state <= ACKED;
                end
                ACKED: if (!e) state <= IDLE;
                RTN: begin
                    if (e)        state <= ack ? ACKED : ACTIVE;
                    else if (ack) state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign alarm = state[1];
    assign unack = state[0];
endmodule

module alarm_annunciator #(
    parameter int N_CH        = 3,
    parameter int PERSIST     = 4,
    parameter int SYNC_STAGES = 2,
    parameter int LATCH       = 1,
    parameter int CW          = $clog2(N_CH + 1),
    parameter int IW          = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic            CLK,
    input  logic            reset_n,
    input  logic [N_CH-1:0] alm_in,
    input  logic [N_CH-1:0] mask,
    input  logic            ack,
    output logic [N_CH-1:0] alarm_o,
    output logic [N_CH-1:0] unack_o,
    output logic            horn,
    output logic [CW-1:0]   active_cnt,
    output logic            first_vld,
    output logic [IW-1:0]   first_idx
);
    logic [N_CH-1:0] alm_s;
    logic [N_CH-1:0] eff;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign alm_s = alm_in;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0][N_CH-1:0] sync_pipe;
            always_ff @(posedge CLK or negedge reset_n) begin
                if (!reset_n) sync_pipe <= '0;
                else begin
                    sync_pipe[0] <= alm_in;
                    for (int s = 1; s < SYNC_STAGES; s++) sync_pipe[s] <= sync_pipe[s-1];
                end
            end
            assign alm_s = sync_pipe[SYNC_STAGES-1];
        end
    endgenerate

    assign eff = alm_s & ~mask;

    generate
        for (genvar i = 0; i < N_CH; i++) begin : g_ch
            alarm_ch #(.PERSIST(PERSIST), .LATCH(LATCH)) u_ch (
                .CLK     (CLK),
                .reset_n (reset_n),
                .e       (eff[i]),
                .ack     (ack),
                .alarm   (alarm_o[i]),
                .unack   (unack_o[i])
            );
        end
    endgenerate

    // Descending scan: the lowest unacknowledged index is written last and wins.
    always_comb begin
        active_cnt = '0;
        first_vld  = 1'b0;
        first_idx  = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            active_cnt = active_cnt + CW'(alarm_o[i]);
            if (unack_o[i]) begin
                first_vld = 1'b1;
                first_idx = IW'(i);
            end
        end
    end

    assign horn = |unack_o;
endmodule

// File: tb/tb_alarm_annunciator.sv
// Randomised bench for alarm_annunciator: three configurations driven in parallel
// and compared every cycle against a flag-based behavioural model.
module tb_alarm_annunciator;
    logic       CLK = 1'b0;
    logic       reset_n;
    logic [7:0] alm, msk;
    logic       ack;

    logic [2:0] a_alarm, a_unack; logic a_horn, a_fv; logic [1:0] a_cnt; logic [1:0] a_fi;
    logic [7:0] b_alarm, b_unack; logic b_horn, b_fv; logic [3:0] b_cnt; logic [2:0] b_fi;
    logic [0:0] c_alarm, c_unack; logic c_horn, c_fv; logic [0:0] c_cnt; logic [0:0] c_fi;

    always #5 CLK = ~CLK;

    alarm_annunciator #(.N_CH(3), .PERSIST(4), .SYNC_STAGES(2), .LATCH(1)) dut_a (
        .CLK(CLK), .reset_n(reset_n), .alm_in(alm[2:0]), .mask(msk[2:0]), .ack(ack),
        .alarm_o(a_alarm), .unack_o(a_unack), .horn(a_horn), .active_cnt(a_cnt),
        .first_vld(a_fv), .first_idx(a_fi));
    alarm_annunciator #(.N_CH(8), .PERSIST(1), .SYNC_STAGES(0), .LATCH(0)) dut_b (
        .CLK(CLK), .reset_n(reset_n), .alm_in(alm), .mask(msk), .ack(ack),
        .alarm_o(b_alarm), .unack_o(b_unack), .horn(b_horn), .active_cnt(b_cnt),
        .first_vld(b_fv), .first_idx(b_fi));
    alarm_annunciator #(.N_CH(1), .PERSIST(2), .SYNC_STAGES(1), .LATCH(0)) dut_c (
        .CLK(CLK), .reset_n(reset_n), .alm_in(alm[0:0]), .mask(msk[0:0]), .ack(ack),
        .alarm_o(c_alarm), .unack_o(c_unack), .horn(c_horn), .active_cnt(c_cnt),
        .first_vld(c_fv), .first_idx(c_fi));

    int cfg_n[3] = '{3, 8, 1};
    int cfg_p[3] = '{4, 1, 2};
    int cfg_s[3] = '{2, 0, 1};
    int cfg_l[3] = '{1, 0, 0};

    // Model: alarm raised / still unacknowledged flags plus a run length of high samples.
    bit         m_raised[3][8];
    bit         m_unack[3][8];
    int         m_run[3][8];
    logic [7:0] hist[4];

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int u = 0; u < 3; u++)
            for (int c = 0; c < 8; c++) begin
                m_raised[u][c] = 1'b0;
                m_unack[u][c]  = 1'b0;
                m_run[u][c]    = 0;
            end
        for (int k = 0; k < 4; k++) hist[k] = '0;
    endtask

    task automatic model_edge();
        logic e;
        for (int k = 3; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = alm;
        for (int u = 0; u < 3; u++)
            for (int c = 0; c < cfg_n[u]; c++) begin
                e = hist[cfg_s[u]][c] & ~msk[c];
                if (!m_raised[u][c] && !m_unack[u][c]) begin
                    if (e) begin
                        m_run[u][c]++;
                        if (m_run[u][c] >= cfg_p[u]) begin
                            m_raised[u][c] = 1'b1;
                            m_unack[u][c]  = 1'b1;
                            m_run[u][c]    = 0;
                        end
                    end else m_run[u][c] = 0;
                end else if (m_raised[u][c]) begin
                    if (e) begin
                        if (ack) m_unack[u][c] = 1'b0;
                    end else begin
                        m_raised[u][c] = 1'b0;
                        m_unack[u][c]  = m_unack[u][c] && (cfg_l[u] != 0) && !ack;
                    end
                end else begin
                    if (e) begin
                        m_raised[u][c] = 1'b1;
                        m_unack[u][c]  = !ack;
                    end else if (ack) m_unack[u][c] = 1'b0;
                end
            end
    endtask

    task automatic check_all(input string ph);
        logic [7:0] ea, eu, ga, gu;
        logic [31:0] gc, gi;
        logic gh, gv;
        int ec, ei;
        bit ev;
        for (int u = 0; u < 3; u++) begin
            ea = '0; eu = '0; ec = 0; ei = 0; ev = 0;
            for (int c = cfg_n[u] - 1; c >= 0; c--) begin
                ea[c] = m_raised[u][c];
                eu[c] = m_unack[u][c];
                ec += int'(m_raised[u][c]);
                if (m_unack[u][c]) begin
                    ev = 1;
                    ei = c;
                end
            end
            case (u)
                0:       begin ga = {5'b0, a_alarm}; gu = {5'b0, a_unack}; gh = a_horn; gv = a_fv; gc = 32'(a_cnt); gi = 32'(a_fi); end
                1:       begin ga = b_alarm; gu = b_unack; gh = b_horn; gv = b_fv; gc = 32'(b_cnt); gi = 32'(b_fi); end
                default: begin ga = {7'b0, c_alarm}; gu = {7'b0, c_unack}; gh = c_horn; gv = c_fv; gc = 32'(c_cnt); gi = 32'(c_fi); end
            endcase
            chk($sformatf("%s_alarm%0d", ph, u), 32'(ga), 32'(ea));
            chk($sformatf("%s_unack%0d", ph, u), 32'(gu), 32'(eu));
            chk($sformatf("%s_horn%0d", ph, u), 32'(gh), 32'(ev));
            chk($sformatf("%s_fvld%0d", ph, u), 32'(gv), 32'(ev));
            chk($sformatf("%s_cnt%0d", ph, u), gc, 32'(ec));
            chk($sformatf("%s_fidx%0d", ph, u), gi, 32'(ei));
        end
    endtask

    task automatic cyc(input string ph);
        @(posedge CLK);
        if (reset_n) model_edge();
        @(negedge CLK);
        check_all(ph);
    endtask

    // Reset asserted between edges: outputs must drop without waiting for a clock.
    task automatic async_rst(input string ph);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all(ph);
        chk({ph, "_horn_a0"}, 32'(a_horn), 32'd0);
        @(negedge CLK);
        reset_n = 1'b1;
    endtask

    initial begin
        int idx;
        reset_n = 1'b0;
        alm = '0; msk = '0; ack = 1'b0;
        model_reset();
        #3;
        check_all("por");
        @(negedge CLK);
        reset_n = 1'b1;

        // Latency: alarm visible after edge 6, silent through edge 5.
        alm = 8'h01;
        for (int k = 1; k <= 6; k++) begin
            cyc("lat");
            if (k == 5) chk("lat_e5_alarm", 32'(a_alarm), 32'd0);
            if (k == 6) begin
                chk("lat_e6_alarm", 32'(a_alarm), 32'h1);
                chk("lat_e6_unack", 32'(a_unack), 32'h1);
                chk("lat_e6_horn",  32'(a_horn),  32'd1);
                chk("lat_e6_cnt",   32'(a_cnt),   32'd1);
                chk("lat_e6_fidx",  32'(a_fi),    32'd0);
            end
        end

        // Glitch on ch1 shorter than the persistence window.
        alm = 8'h03;
        for (int k = 0; k < 3; k++) cyc("glitch");
        alm = 8'h01;
        for (int k = 0; k < 6; k++) cyc("glitch");
        chk("glitch_alarm", 32'(a_alarm), 32'h1);

        // Latch: ch2 active then released without ack parks in RTN.
        alm = 8'h05;
        for (int k = 0; k < 6; k++) cyc("latch");
        alm = 8'h01;
        for (int k = 0; k < 3; k++) cyc("latch");
        chk("rtn_alarm", 32'(a_alarm), 32'h1);
        chk("rtn_unack", 32'(a_unack), 32'h5);
        ack = 1'b1;
        cyc("ack");
        ack = 1'b0;
        chk("ack_unack", 32'(a_unack), 32'h0);
        chk("ack_alarm", 32'(a_alarm), 32'h1);
        for (int k = 0; k < 3; k++) cyc("acked");

        async_rst("rst_active");
        msk = 8'h01;
        for (int k = 0; k < 8; k++) cyc("mask");
        chk("mask_alarm", 32'(a_alarm), 32'h0);
        msk = '0;

        alm = 8'hFF;
        for (int k = 0; k < 8; k++) cyc("all");
        chk("all_cnt_b", 32'(b_cnt), 32'd8);
        chk("all_cnt_a", 32'(a_cnt), 32'd3);
        ack = 1'b1;
        cyc("all_ack");
        ack = 1'b0;
        alm = 8'hFD;
        for (int k = 0; k < 4; k++) cyc("simul");
        alm = 8'hFF;
        for (int k = 0; k < 7; k++) cyc("reraise");
        chk("reraise_fidx", 32'(a_fi), 32'd1);

        alm = 8'h00;
        for (int k = 0; k < 4; k++) cyc("drop");
        alm = 8'hFF;
        cyc("pend");
        cyc("pend");
        async_rst("rst_pend");
        for (int k = 0; k < 8; k++) cyc("relat");

        for (int t = 0; t < 1500; t++) begin
            for (int b = 0; b < 8; b++)
                if ($urandom_range(7) == 0) alm[b] = ~alm[b];
            if ($urandom_range(31) == 0) begin
                idx = int'($urandom_range(7));
                msk[idx] = ~msk[idx];
            end
            if ($urandom_range(63) == 0) msk = '0;
            ack = ($urandom_range(5) == 0);
            if ($urandom_range(399) == 0) async_rst("rnd_rst");
            cyc("rnd");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
